seq_divider: RTL and testbench

Iterative 32-bit radix-2 divide/remainder unit for the execute stage; it takes the four RV32M divide-class operations off the single-cycle ALU path. It uses the same `alu_control` opcode encoding and the same result conventions as the ALU. The execute stage issues operands through a valid/ready handshake and stalls on `in_ready`/`busy`. Results return through a second valid/ready handshake, with the ALU-style `zero` flag.

---
 rtl/seq_divider.sv | 194 +++++++++++++++++++
 tb/tb_seq_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module      : seq_divider
// Description : Iterative 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU
//               behind valid/ready handshakes. Optional macro:
//               SEQ_DIV_EARLY_OUT_EN (1-cycle result for b==0 or |a|<|b|).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [5:0] c_op_div  = 6'b001010;
    localparam logic [5:0] c_op_divu = 6'b001011;
    localparam logic [5:0] c_op_rem  = 6'b001100;
    localparam logic [5:0] c_op_remu = 6'b001101;

    localparam logic [WIDTH-1:0] c_div0_result = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0]       c_last_step   = 5'd31;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [4:0]       r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_is_rem;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

    // Operation decode at the request port
    logic             w_op_valid;
    logic             w_op_signed;
    logic             w_op_rem;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_early;
    logic [WIDTH-1:0] w_early_result;

    always_comb begin
        w_op_valid  = 1'b1;
        w_op_signed = 1'b0;
        w_op_rem    = 1'b0;
        case (alu_control)
            c_op_div:  w_op_signed = 1'b1;
            c_op_divu: w_op_signed = 1'b0;
            c_op_rem:  begin w_op_signed = 1'b1; w_op_rem = 1'b1; end
            c_op_remu: w_op_rem = 1'b1;
            default:   w_op_valid = 1'b0;
        endcase
    end

    assign w_a_mag = (w_op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_b_mag = (w_op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

`ifdef SEQ_DIV_EARLY_OUT_EN
    // Quotient is 0 and remainder is the original dividend when |a| < |b|
    assign w_early        = (b == '0) || (w_a_mag < w_b_mag);
    assign w_early_result = (b == '0) ? c_div0_result : (w_op_rem ? a : '0);
`else
    assign w_early        = 1'b0;
    assign w_early_result = '0;
`endif

    // One restoring step: shift in the next dividend bit, trial subtract
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_rem_final;
    logic [WIDTH-1:0] w_final;

    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = w_shift[WIDTH] || (w_shift[WIDTH-1:0] >= r_div);
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    assign w_quo_final = r_q_neg ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_final = r_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_final     = r_div_zero ? c_div0_result
                                    : (r_is_rem ? w_rem_final : w_quo_final);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    if (!w_op_valid || w_early) w_state_next = c_st_done;
                    else                        w_state_next = c_st_calc;
                end
            end
            c_st_calc: begin
                if (r_count == c_last_step) w_state_next = c_st_done;
            end
            c_st_done: begin
                if (out_ready) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
        if (flush) w_state_next = c_st_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_is_rem    <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_count     <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_next == c_st_done);
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_count    <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_a_mag;
                        r_div      <= w_b_mag;
                        r_is_rem   <= w_op_rem;
                        r_q_neg    <= w_op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_r_neg    <= w_op_signed && a[WIDTH-1];
                        r_div_zero <= (b == '0);
                        if (!w_op_valid) begin
                            r_result <= '0;
                            r_zero   <= 1'b1;
                        end else if (w_early) begin
                            r_result <= w_early_result;
                            r_zero   <= (w_early_result == '0);
                        end
                    end
                end
                c_st_calc: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == c_last_step) begin
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign busy      = (r_state == c_st_calc) || (r_state == c_st_done);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider with an arithmetic
//               reference model; honours SEQ_DIV_EARLY_OUT_EN for latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

    localparam logic [5:0] c_div  = 6'b001010;
    localparam logic [5:0] c_divu = 6'b001011;
    localparam logic [5:0] c_rem  = 6'b001100;
    localparam logic [5:0] c_remu = 6'b001101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [5:0]  alu_control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics, with div-by-zero forced to 0x80000000
    function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic signed [31:0] sa, sb;
        sa = av; sb = bv;
        if (op != c_div && op != c_divu && op != c_rem && op != c_remu) return 32'h0;
        if (bv == 32'h0) return 32'h8000_0000;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            if (op == c_div) return 32'h8000_0000;
            if (op == c_rem) return 32'h0;
        end
        case (op)
            c_div:   return sa / sb;
            c_rem:   return sa % sb;
            c_divu:  return av / bv;
            default: return av % bv;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] am, bm;
        logic        sgn;
        if (op != c_div && op != c_divu && op != c_rem && op != c_remu) return 0;
        sgn = (op == c_div) || (op == c_rem);
        am = (sgn && av[31]) ? -av : av;
        bm = (sgn && bv[31]) ? -bv : bv;
`ifdef SEQ_DIV_EARLY_OUT_EN
        if (bv == 32'h0 || am < bm) return 0;
`else
        if (am == bm && am == 32'hDEAD_BEEF) return 0;  // never: full iteration always
`endif
        return 32;
    endfunction

    // Present a request; returns at the negedge after the acceptance edge
    task automatic start_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) check("wait_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1; alu_control = op; a = av; b = bv;
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 6'($urandom);
    endtask

    // Edges after the acceptance edge until out_valid is seen
    task automatic wait_valid(output int idx);
        idx = 0;
        while (!out_valid && idx < 40) begin @(negedge clk); idx++; end
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] er;
        int          idx;
        er = ref_result(op, av, bv);
        start_op(op, av, bv);
        wait_valid(idx);
        check({tag, "_latency"}, 32'(idx), 32'(ref_latency(op, av, bv)));
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, 32'(zero), 32'(er == 32'h0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {30'h0, in_ready, out_valid}, 32'h2);
    endtask

    initial begin
        int          idx;
        logic [31:0] held;
        logic [5:0]  op;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        check("reset_state", {27'h0, in_ready, out_valid, busy, zero, 1'b0}, {27'h0, 5'b10000});
        check("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", c_divu, 32'd100, 32'd7);
        run_op("remu_100_7", c_remu, 32'd100, 32'd7);
        run_op("div_m7_2",   c_div,  32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",   c_rem,  32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf",    c_div,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",    c_rem,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op("remu_b0",    c_remu, 32'd1234, 32'd0);
        run_op("div_b0",     c_div,  32'hFFFF_0000, 32'd0);
        run_op("divu_3_9",   c_divu, 32'd3, 32'd9);
        run_op("rem_m3_5",   c_rem,  32'hFFFF_FFFD, 32'd5);
        run_op("unsupported", 6'b000001, 32'd77, 32'd3);

        // Back-pressure: result holds and new requests are ignored
        start_op(c_divu, 32'd1000, 32'd7);
        wait_valid(idx);
        check("bp_first", result, 32'd142);
        held = result;
        in_valid = 1'b1; alu_control = c_divu; a = 32'd9; b = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_result", result, held);
            check("bp_hold_flags", {29'h0, in_ready, out_valid, busy}, 32'h3);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {30'h0, in_ready, busy}, 32'h2);
        @(negedge clk);
        check("bp_no_accept", 32'(busy), 32'h0);

        // Flush during CALC step 10
        start_op(c_divu, 32'd1000, 32'd3);
        repeat (10) begin
            check("flush_pre_valid", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {30'h0, in_ready, out_valid}, 32'h2);
        check("flush_result_clear", {result[30:0], zero}, 32'h0);
        // Flush beats a simultaneous request in IDLE
        flush = 1'b1; in_valid = 1'b1; alu_control = c_divu; a = 32'd8; b = 32'd2;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drops_req", {30'h0, in_ready, busy}, 32'h2);

        // Asynchronous reset during CALC step 20
        start_op(c_divu, 32'd1000, 32'd3);
        repeat (20) begin
            check("rst_pre_valid", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("rst_async_idle", {29'h0, in_ready, out_valid, busy}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_50_5", c_divu, 32'd50, 32'd5);

        // Randomized operations against the reference model
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 6'($urandom);
                1, 2:    op = c_div;
                3, 4:    op = c_divu;
                5, 6:    op = c_rem;
                default: op = c_remu;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1, 2:    rb = 32'($urandom_range(1, 50));
                3:       rb = -32'($urandom_range(1, 50));
                4:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                5:       begin ra = 32'($urandom_range(0, 20)); rb = $urandom; end
                default: rb = $urandom;
            endcase
            run_op("random", op, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
